// File: rtl/morse_symbol_assembler.sv
// -----------------------------------------------------------------------------
// morse_symbol_assembler
//
// Collects dot/dash press pulses from the debounced Morse buttons into a
// symbol buffer of up to five symbols. On a letter commit it decodes the
// buffer to an ASCII character (A-Z, 0-9). The character is then offered
// downstream over a valid/ready handshake.
//
// Ports:
//   clk         system clock, all logic on posedge
//   rst         asynchronous, active-high reset
//   dot_p       one-cycle dot pulse
//   dash_p      one-cycle dash pulse
//   commit_p    one-cycle end-of-letter pulse
//   clear_p     one-cycle discard-partial-letter pulse
//   char_out    decoded ASCII character, stable while char_valid=1
//   char_valid  character available
//   char_ready  consumer accepts char_out when char_valid && char_ready
//   char_err    1: unknown code or overflow (char_out = '?')
//   sym_count   symbols currently buffered (0..5)
//   drop_p      one-cycle pulse: an input pulse was discarded
//
// Optional feature (macro MORSE_AUTO_COMMIT_EN): an idle counter commits
// the letter automatically TIMEOUT_CYCLES after the last accepted symbol.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module morse_symbol_assembler #(
    parameter int MAX_SYMBOLS    = 5,
    parameter int TIMEOUT_CYCLES = 67108864
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dot_p,
    input  logic       dash_p,
    input  logic       commit_p,
    input  logic       clear_p,
    output logic [7:0] char_out,
    output logic       char_valid,
    input  logic       char_ready,
    output logic       char_err,
    output logic [2:0] sym_count,
    output logic       drop_p
);

    typedef enum logic [1:0] {COLLECT, DECODE, HOLD} state_t;

    localparam logic [2:0] LEN_MAX = 3'(MAX_SYMBOLS);

    state_t     state_reg, state_next;
    logic [2:0] len_reg,   len_next;
    logic [4:0] bits_reg,  bits_next;
    logic       ovf_reg,   ovf_next;
    logic [7:0] char_reg,  char_next;
    logic       valid_reg, valid_next;
    logic       err_reg,   err_next;
    logic       drop_reg,  drop_next;

    // Buffer contents after appending this cycle's symbol (if any).
    logic [2:0] len_app;
    logic [4:0] bits_app;
    logic       ovf_app;
    logic       sym_one, sym_both, sym_accept;
    logic       commit_any, auto_commit, any_in;
    logic [7:0] code;

    assign sym_one    = dot_p ^ dash_p;
    assign sym_both   = dot_p & dash_p;
    assign any_in     = dot_p | dash_p | commit_p | clear_p;
    assign sym_accept = (state_reg == COLLECT) && !clear_p && sym_one && (len_reg < LEN_MAX);
    assign commit_any = commit_p | auto_commit;

`ifdef MORSE_AUTO_COMMIT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timer_reg;

    // Idle counter: runs only while a partial letter is pending and
    // saturates so the internal commit stays asserted until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_reg <= '0;
        end else if (state_reg != COLLECT || clear_p || sym_accept) begin
            timer_reg <= '0;
        end else if ((len_reg != 3'd0 || ovf_reg) && timer_reg != TMAX) begin
            timer_reg <= timer_reg + 1'b1;
        end
    end

    assign auto_commit = (state_reg == COLLECT) && (timer_reg == TMAX);
`else
    assign auto_commit = 1'b0;
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
    end
`endif

    // Lookup keyed on length; the first symbol sits at the MSB of the used
    // field, so each pattern reads as a binary number with dash=1.
    function automatic logic [7:0] lookup(input logic [2:0] len, input logic [4:0] bits);
        logic [7:0] c;
        c = 8'h00;
        case (len)
            3'd1: c = bits[0] ? 8'h54 : 8'h45;                     // T E
            3'd2: case (bits[1:0])
                2'd0: c = 8'h49; 2'd1: c = 8'h41;                   // I A
                2'd2: c = 8'h4E; default: c = 8'h4D;                // N M
            endcase
            3'd3: case (bits[2:0])
                3'd0: c = 8'h53; 3'd1: c = 8'h55;                   // S U
                3'd2: c = 8'h52; 3'd3: c = 8'h57;                   // R W
                3'd4: c = 8'h44; 3'd5: c = 8'h4B;                   // D K
                3'd6: c = 8'h47; default: c = 8'h4F;                // G O
            endcase
            3'd4: case (bits[3:0])
                4'd0:  c = 8'h48; 4'd1:  c = 8'h56; 4'd2:  c = 8'h46; // H V F
                4'd4:  c = 8'h4C; 4'd6:  c = 8'h50; 4'd7:  c = 8'h4A; // L P J
                4'd8:  c = 8'h42; 4'd9:  c = 8'h58; 4'd10: c = 8'h43; // B X C
                4'd11: c = 8'h59; 4'd12: c = 8'h5A; 4'd13: c = 8'h51; // Y Z Q
                default: c = 8'h00;
            endcase
            3'd5: case (bits)
                5'd31: c = 8'h30; 5'd15: c = 8'h31; 5'd7:  c = 8'h32;
                5'd3:  c = 8'h33; 5'd1:  c = 8'h34; 5'd0:  c = 8'h35;
                5'd16: c = 8'h36; 5'd24: c = 8'h37; 5'd28: c = 8'h38;
                5'd30: c = 8'h39;
                default: c = 8'h00;
            endcase
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    assign code = lookup(len_reg, bits_reg);

    // Symbol append; a symbol on a full buffer only raises the sticky ovf.
    always_comb begin
        len_app  = len_reg;
        bits_app = bits_reg;
        ovf_app  = ovf_reg;
        if (sym_one) begin
            if (len_reg < LEN_MAX) begin
                bits_app = {bits_reg[3:0], dash_p};
                len_app  = len_reg + 3'd1;
            end else begin
                ovf_app = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= COLLECT;
        else     state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            COLLECT: if (!clear_p && commit_any && (len_app != 3'd0 || ovf_app))
                         state_next = DECODE;
            DECODE:  state_next = HOLD;
            HOLD:    if (char_ready) state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        len_next   = len_reg;
        bits_next  = bits_reg;
        ovf_next   = ovf_reg;
        char_next  = char_reg;
        valid_next = valid_reg;
        err_next   = err_reg;
        drop_next  = 1'b0;
        case (state_reg)
            COLLECT: begin
                if (clear_p) begin
                    len_next  = 3'd0;
                    bits_next = 5'd0;
                    ovf_next  = 1'b0;
                end else begin
                    len_next  = len_app;
                    bits_next = bits_app;
                    ovf_next  = ovf_app;
                    drop_next = sym_both | (sym_one && len_reg == LEN_MAX);
                end
            end
            DECODE: begin
                if (ovf_reg || code == 8'h00) begin
                    char_next = 8'h3F;
                    err_next  = 1'b1;
                end else begin
                    char_next = code;
                    err_next  = 1'b0;
                end
                valid_next = 1'b1;
                len_next   = 3'd0;
                bits_next  = 5'd0;
                ovf_next   = 1'b0;
                drop_next  = any_in;
            end
            HOLD: begin
                drop_next = any_in;
                if (char_ready) valid_next = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_reg   <= 3'd0;
            bits_reg  <= 5'd0;
            ovf_reg   <= 1'b0;
            char_reg  <= 8'h00;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
            drop_reg  <= 1'b0;
        end else begin
            len_reg   <= len_next;
            bits_reg  <= bits_next;
            ovf_reg   <= ovf_next;
            char_reg  <= char_next;
            valid_reg <= valid_next;
            err_reg   <= err_next;
            drop_reg  <= drop_next;
        end
    end

    assign char_out   = char_reg;
    assign char_valid = valid_reg;
    assign char_err   = err_reg;
    assign sym_count  = len_reg;
    assign drop_p     = drop_reg;

endmodule

// File: doc/morse_symbol_assembler.md
Name: morse_symbol_assembler

Overview:
- Sits directly downstream of the per-button Morse debouncers.
- Consumes their single-cycle press pulses (dot, dash, letter-commit, clear).
- Accumulates up to 5 dot/dash symbols, then decodes the sequence to an ASCII character on commit.
- Presents the character to the display/text-buffer stage over a valid/ready handshake.

Parameters:
- MAX_SYMBOLS, 5, capacity of the symbol buffer. Fixed at 5 for the lookup table; other values are unsupported.
- TIMEOUT_CYCLES, 67108864, idle cycles after the last symbol before auto-commit (optional feature only; about 0.67 s at 100 MHz).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- dot_p  input  1  one-cycle pulse from the debounced dot button.
- dash_p  input  1  one-cycle pulse from the debounced dash button.
- commit_p  input  1  one-cycle pulse: end of letter.
- clear_p  input  1  one-cycle pulse: discard the partial letter.
- char_out  output  8  ASCII character; stable while char_valid=1.
- char_valid  output  1  character available.
- char_ready  input  1  consumer accepts char_out on a cycle where char_valid=1 and char_ready=1.
- char_err  output  1  qualifies char_out: 1 means unknown code or overflow, with char_out = 0x3F ('?').
- sym_count  output  3  symbols currently buffered (0..5); drives the progress LEDs.
- drop_p  output  1  one-cycle pulse: an input pulse was discarded.

Behaviour:
- Reset values (asynchronous, active-high):
  - char_out=0x00, char_valid=0, char_err=0, drop_p=0, sym_count=0.
  - Buffer bits=5'b0, ovf=0, state=COLLECT.
- Buffer encoding:
  - dot=0, dash=1.
  - On each accepted symbol: bits <= {bits[3:0], sym}, len <= len+1.
  - First symbol ends at the MSB of the used field. Example: A (.-) is len=2, bits=xxx01.
- Overflow:
  - A symbol arriving when len=5 sets sticky ovf=1.
  - len stays 5, bits are unchanged, drop_p=1.
- Symbol validity: dot_p and dash_p in the same cycle are both ignored and pulse drop_p=1.
- States:
  - COLLECT:
    - Accepts symbols.
    - clear_p: len=0, ovf=0, bits=0. clear_p takes priority over a symbol or commit in the same cycle.
    - commit_p with len=0 and ovf=0 is ignored; no character is produced.
    - commit_p otherwise: go to DECODE next cycle.
    - A symbol in the same cycle as commit_p is appended first, then committed.
  - DECODE (one cycle):
    - Combinational lookup on (len, bits) covers A-Z and 0-9 (ITU); result is registered into char_out.
    - Unknown pattern or ovf=1: char_out=0x3F, char_err=1. Otherwise char_err=0.
    - Sets char_valid=1 and clears the buffer (len=0, ovf=0); go to HOLD.
  - HOLD:
    - char_valid=1 with char_out and char_err held.
    - char_valid && char_ready: char_valid=0 next cycle, return to COLLECT.
    - Any dot_p/dash_p/commit_p/clear_p arriving in HOLD is dropped with drop_p=1.
- Latency: commit_p at cycle N gives char_valid high from cycle N+2. Acceptance at cycle M gives symbols accepted again from cycle M+1.
- sym_count always equals the registered len.
- Reset mid-operation discards everything, including an unacknowledged character.

Optional Feature:
- Macro: MORSE_AUTO_COMMIT_EN.
- Defined:
  - A counter clears on every accepted symbol.
  - It increments in COLLECT while len>0 or ovf=1, and saturates at TIMEOUT_CYCLES-1.
  - Reaching TIMEOUT_CYCLES-1 acts as an internal commit_p on the next cycle.
  - The counter clears on clear_p, DECODE and reset.
- Undefined: no counter is synthesized and only an explicit commit_p produces a character.

Test Plan:
- dot_p, dash_p, commit_p, then char_ready held high -> char_out=0x41 ('A'), char_err=0, char_valid for 1 cycle starting 2 cycles after commit_p; sym_count 1,2,0.
- dash,dash,dash,dash,dash then commit_p -> char_out=0x30 ('0'); dot,dot,dot,dot,dot -> 0x35 ('5').
- Six dot_p pulses then commit_p -> drop_p on the 6th pulse, sym_count stays 5, char_out=0x3F with char_err=1.
- dot,dash,dot,dash,dash (unlisted) then commit_p -> 0x3F with char_err=1. Separately, commit_p with an empty buffer -> no char_valid.
- char_ready held low 10 cycles after 'E' (dot then commit) -> char_out=0x45 stable throughout; dot_p during the wait -> drop_p=1, sym_count stays 0; char_ready=1 -> accepted, then a new dot is accepted.
- dot,dash then clear_p with simultaneous commit_p -> buffer emptied, no char. rst pulse during HOLD -> char_valid=0 asynchronously. With MORSE_AUTO_COMMIT_EN and TIMEOUT_CYCLES=16: dash then idle -> char_out=0x54 ('T') with no commit_p.
